hazard_ctrl: RTL and testbench

//  Pipeline hazard and stall controller for the 5-stage RV32I core. Works beside the
//  EX-stage operand forwarding logic and covers the hazards forwarding cannot resolve:
//  - load-use: inserts one bubble
//  - taken branch/jump in EX: flushes wrong-path instructions
//  - outstanding imem/dmem accesses: freezes the whole pipeline

---
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipeline: load-use bubbles,
// taken-branch flushes, memory-wait freezes and saturating event counters.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_s,
    input  logic [4:0]       id_rs2_s,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd_s,
    input  logic             ex_br_taken,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             freeze,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       wait_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // State encoding is {dmem_busy, imem_busy}; each bit evolves independently.
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        IWAIT  = 2'b01,
        DWAIT  = 2'b10,
        IDWAIT = 2'b11
    } wait_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wait_e state, state_next;
    logic  imem_busy, dmem_busy;
    logic  imem_busy_next, dmem_busy_next;
    logic  load_use;

    assign imem_busy  = state[0];
    assign dmem_busy  = state[1];
    assign wait_state = state;

    // NOTE: sequential state uses non-blocking (<=) so all registers update from
    // the same pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // A request answered in the same cycle is zero-wait and never sets busy.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        imem_busy_next = (imem_busy | imem_req) & ~imem_resp;
        dmem_busy_next = (dmem_busy | dmem_req) & ~dmem_resp;
        state_next     = wait_e'({dmem_busy_next, imem_busy_next});
    end

    assign load_use = ex_valid & ex_is_load & (ex_rd_s != 5'd0) &
                      ((ex_rd_s == id_rs1_s) | (ex_rd_s == id_rs2_s));

    // Strict priority: freeze, then taken branch (ID is wrong-path), then load-use.
    always_comb begin
        freeze       = 1'b0;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        if (!rst) begin
            if ((imem_busy & ~imem_resp) | (dmem_busy & ~dmem_resp)) begin
                freeze = 1'b1;
            end else if (ex_br_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    // Event counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (freeze && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (bubble_id_ex && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
            if (flush_id_ex && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; counters sized to 4 bits so
// saturation is reachable in a short run.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1_s, id_rs2_s, ex_rd_s;
    logic             ex_valid, ex_is_load, ex_br_taken;
    logic             imem_req, imem_resp, dmem_req, dmem_resp;
    logic             freeze, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex;
    logic [1:0]       wait_state;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_s(id_rs1_s), .id_rs2_s(id_rs2_s),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd_s(ex_rd_s),
        .ex_br_taken(ex_br_taken),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .freeze(freeze), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .wait_state(wait_state),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Control vector order: {freeze, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex}
    task automatic check_ctrl(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, freeze, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex},
              {27'd0, exp});
    endtask

    // Advance to just after the next rising edge; inputs set here apply to the new cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Move to mid-cycle, away from the active edge, before sampling outputs.
    task automatic settle();
        #4;
    endtask

    task automatic clear_inputs();
        id_rs1_s = 5'd0; id_rs2_s = 5'd0; ex_rd_s = 5'd0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
        imem_req = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ex_valid = 1'b1; ex_is_load = 1'b1;
        ex_rd_s = rd; id_rs1_s = rs1; id_rs2_s = rs2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        // Reset forces controls low even with a load-use hazard present
        set_load_use(5'd5, 5'd0, 5'd5);
        ex_br_taken = 1'b1;
        settle();
        check_ctrl("rst_ctrl_zero", 5'b00000);
        check("rst_wait_state", {30'd0, wait_state}, 32'd0);
        check("rst_counters", {20'd0, stall_cnt, bubble_cnt, flush_cnt}, 32'd0);
        clear_inputs();
        rst = 1'b0;
        next_cycle();

        // T1: load-use on rs2, then bubble, then rd=x0, rs1 match, non-load
        set_load_use(5'd5, 5'd0, 5'd5);
        settle();
        check_ctrl("t1_load_use_rs2", 5'b01100);
        check("t1_bubble_cnt_before", {28'd0, bubble_cnt}, 32'd0);
        next_cycle();
        ex_valid = 1'b0;
        settle();
        check_ctrl("t1_after_bubble", 5'b00000);
        check("t1_bubble_cnt_after", {28'd0, bubble_cnt}, 32'd1);
        next_cycle();
        set_load_use(5'd0, 5'd0, 5'd0);
        settle();
        check_ctrl("t1_rd_x0", 5'b00000);
        next_cycle();
        set_load_use(5'd7, 5'd7, 5'd3);
        settle();
        check_ctrl("t1_load_use_rs1", 5'b01100);
        next_cycle();
        set_load_use(5'd9, 5'd9, 5'd9);
        ex_is_load = 1'b0;
        settle();
        check_ctrl("t1_not_load", 5'b00000);
        check("t1_bubble_cnt_two", {28'd0, bubble_cnt}, 32'd2);

        // T2: taken branch wins over load-use
        do_reset();
        set_load_use(5'd5, 5'd0, 5'd5);
        ex_br_taken = 1'b1;
        settle();
        check_ctrl("t2_branch_flush", 5'b00011);
        next_cycle();
        clear_inputs();
        settle();
        check("t2_flush_cnt", {28'd0, flush_cnt}, 32'd1);
        check("t2_bubble_cnt", {28'd0, bubble_cnt}, 32'd0);

        // T3: dmem access with three-cycle latency
        do_reset();
        dmem_req = 1'b1;
        settle();
        check_ctrl("t3_c0_ctrl", 5'b00000);
        check("t3_c0_ws", {30'd0, wait_state}, 32'd0);
        next_cycle();
        dmem_req = 1'b0;
        settle();
        check_ctrl("t3_c1_freeze", 5'b10000);
        check("t3_c1_ws", {30'd0, wait_state}, 32'h2);
        next_cycle();
        settle();
        check_ctrl("t3_c2_freeze", 5'b10000);
        next_cycle();
        dmem_resp = 1'b1;
        settle();
        check_ctrl("t3_c3_resp_unfrozen", 5'b00000);
        check("t3_c3_ws", {30'd0, wait_state}, 32'h2);
        next_cycle();
        dmem_resp = 1'b0;
        settle();
        check("t3_c4_ws", {30'd0, wait_state}, 32'h0);
        check("t3_stall_cnt", {28'd0, stall_cnt}, 32'd2);

        // T4: zero-wait fetch, then overlapping imem/dmem waits
        do_reset();
        imem_req = 1'b1; imem_resp = 1'b1;
        settle();
        check_ctrl("t4_zero_wait_ctrl", 5'b00000);
        next_cycle();
        imem_req = 1'b0; imem_resp = 1'b0;
        settle();
        check("t4_zero_wait_ws", {30'd0, wait_state}, 32'h0);
        check_ctrl("t4_zero_wait_after", 5'b00000);
        imem_req = 1'b1;
        next_cycle();
        imem_req = 1'b0; dmem_req = 1'b1;
        settle();
        check_ctrl("t4_c1_freeze", 5'b10000);
        check("t4_c1_ws", {30'd0, wait_state}, 32'h1);
        next_cycle();
        dmem_req = 1'b0; imem_resp = 1'b1;
        settle();
        check_ctrl("t4_c2_freeze", 5'b10000);
        check("t4_c2_ws", {30'd0, wait_state}, 32'h3);
        next_cycle();
        imem_resp = 1'b0;
        settle();
        check_ctrl("t4_c3_freeze", 5'b10000);
        check("t4_c3_ws", {30'd0, wait_state}, 32'h2);
        next_cycle();
        dmem_resp = 1'b1;
        settle();
        check_ctrl("t4_c4_unfrozen", 5'b00000);
        next_cycle();
        dmem_resp = 1'b0;
        settle();
        check("t4_c5_ws", {30'd0, wait_state}, 32'h0);
        check("t4_stall_cnt", {28'd0, stall_cnt}, 32'd3);

        // T5: reset in the middle of a dmem wait; late response ignored
        do_reset();
        dmem_req = 1'b1;
        next_cycle();
        dmem_req = 1'b0;
        settle();
        check("t5_c1_ws", {30'd0, wait_state}, 32'h2);
        next_cycle();
        rst = 1'b1;
        settle();
        check_ctrl("t5_c2_rst_no_freeze", 5'b00000);
        check("t5_c2_stall_cnt", {28'd0, stall_cnt}, 32'd1);
        next_cycle();
        rst = 1'b0; dmem_resp = 1'b1;
        settle();
        check("t5_c3_ws", {30'd0, wait_state}, 32'h0);
        check_ctrl("t5_c3_ctrl", 5'b00000);
        check("t5_c3_counters", {20'd0, stall_cnt, bubble_cnt, flush_cnt}, 32'd0);
        next_cycle();
        dmem_resp = 1'b0;
        settle();
        check("t5_c4_ws", {30'd0, wait_state}, 32'h0);

        // T6: 20 frozen cycles saturate stall_cnt; branch held in frozen EX
        do_reset();
        imem_req = 1'b1;
        next_cycle();
        imem_req = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c >= 18) ex_br_taken = 1'b1;
            settle();
            if (c == 1 || c >= 18) check_ctrl($sformatf("t6_frozen_c%0d", c), 5'b10000);
            next_cycle();
        end
        imem_resp = 1'b1;
        settle();
        check_ctrl("t6_first_unfrozen_flush", 5'b00011);
        next_cycle();
        clear_inputs();
        settle();
        check_ctrl("t6_after_flush", 5'b00000);
        check("t6_stall_cnt_sat", {28'd0, stall_cnt}, 32'd15);
        check("t6_flush_cnt", {28'd0, flush_cnt}, 32'd1);
        check("t6_ws_idle", {30'd0, wait_state}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
